// File: rtl/multiplier_pipe_stream.sv
// multiplier_pipe_stream: fully pipelined signed/unsigned array multiplier with a valid/ready stream handshake.
// Each of the S stages adds rows_per_stage partial-product rows; the whole pipe freezes while the output is blocked.
module multiplier_pipe_stream #(
   parameter int bw             = 16,
   parameter int rows_per_stage = 4
) (
   input  logic            CLK,
   input  logic            RESETn,
   input  logic [bw:1]     A,
   input  logic [bw:1]     B,
   input  logic            in_signed,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [2*bw:1]   out,
   output logic            out_signed,
   output logic            out_valid,
   input  logic            out_ready
);
   localparam int S = bw / rows_per_stage;
   localparam int W = 2 * bw;

   if (bw % rows_per_stage != 0) begin : g_bad_rows
      $error("rows_per_stage must divide bw");
   end

   logic          r_vld [1:S];
   logic          r_sgn [1:S];
   logic [bw-1:0] r_a   [1:S];
   logic [bw-1:0] r_b   [1:S];
   logic [W-1:0]  r_sum [1:S];

   logic          w_vld  [0:S-1];
   logic          w_sgn  [0:S-1];
   logic [bw-1:0] w_a    [0:S-1];
   logic [bw-1:0] w_b    [0:S-1];
   logic [W-1:0]  w_sum  [0:S-1];
   logic [W-1:0]  w_nsum [0:S-1];
   logic          w_en;

   // In signed mode the top multiplier bit carries weight -2^(bw-1), so its row is subtracted.
   function automatic logic [W-1:0] add_rows(input logic [W-1:0] sum, input logic [bw-1:0] a,
                                             input logic [bw-1:0] b, input logic sg, input int first);
      logic [W-1:0] a_ext;
      logic [W-1:0] row;
      int           j;
      a_ext = sg ? {{bw{a[bw-1]}}, a} : {{bw{1'b0}}, a};
      for (int r = 0; r < rows_per_stage; r++) begin
         j   = first + r;
         row = b[j] ? a_ext << j : '0;
         sum = (sg && j == bw - 1) ? sum - row : sum + row;
      end
      return sum;
   endfunction

   // Bubbles enter with zeroed operands so out only ever shows 0 or a real product.
   always_comb begin
      w_en     = !(r_vld[S] && !out_ready);
      w_vld[0] = in_valid;
      w_sgn[0] = in_valid & in_signed;
      w_a[0]   = in_valid ? A : '0;
      w_b[0]   = in_valid ? B : '0;
      w_sum[0] = '0;
      for (int k = 1; k < S; k++) begin
         w_vld[k] = r_vld[k];
         w_sgn[k] = r_sgn[k];
         w_a[k]   = r_a[k];
         w_b[k]   = r_b[k];
         w_sum[k] = r_sum[k];
      end
      for (int k = 0; k < S; k++)
         w_nsum[k] = add_rows(w_sum[k], w_a[k], w_b[k], w_sgn[k], k * rows_per_stage);
   end

   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn)
         for (int k = 1; k <= S; k++) begin
            r_vld[k] <= 1'b0;
            r_sgn[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
         end
      else if (w_en)
         for (int k = 1; k <= S; k++) begin
            r_vld[k] <= w_vld[k-1];
            r_sgn[k] <= w_sgn[k-1];
            r_a[k]   <= w_a[k-1];
            r_b[k]   <= w_b[k-1];
            r_sum[k] <= w_nsum[k-1];
         end

   assign in_ready   = w_en;
   assign out        = r_sum[S];
   assign out_signed = r_sgn[S];
   assign out_valid  = r_vld[S];
endmodule

// File: tb/tb_multiplier_pipe_stream.sv
// tb_multiplier_pipe_stream: directed stimulus with a product scoreboard for the S=4 instance,
// plus S=16 and S=1 instances checked for reset behaviour and latency scaling.
module tb_multiplier_pipe_stream;
   localparam int BW = 16;

   logic          CLK = 1'b0;
   logic          RESETn = 1'b0;
   logic [BW:1]   A = '0;
   logic [BW:1]   B = '0;
   logic          in_signed = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic          in_ready, out_signed, out_valid;
   logic [2*BW:1] out;
   logic          in_ready1, out_signed1, out_valid1;
   logic [2*BW:1] out1;
   logic          in_ready16, out_signed16, out_valid16;
   logic [2*BW:1] out16;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 CLK = ~CLK;

   multiplier_pipe_stream #(.bw(BW), .rows_per_stage(4)) dut (
      .CLK(CLK), .RESETn(RESETn), .A(A), .B(B), .in_signed(in_signed), .in_valid(in_valid),
      .in_ready(in_ready), .out(out), .out_signed(out_signed), .out_valid(out_valid), .out_ready(out_ready));
   multiplier_pipe_stream #(.bw(BW), .rows_per_stage(1)) dut_s16 (
      .CLK(CLK), .RESETn(RESETn), .A(A), .B(B), .in_signed(in_signed), .in_valid(in_valid),
      .in_ready(in_ready1), .out(out1), .out_signed(out_signed1), .out_valid(out_valid1), .out_ready(out_ready));
   multiplier_pipe_stream #(.bw(BW), .rows_per_stage(16)) dut_s1 (
      .CLK(CLK), .RESETn(RESETn), .A(A), .B(B), .in_signed(in_signed), .in_valid(in_valid),
      .in_ready(in_ready16), .out(out16), .out_signed(out_signed16), .out_valid(out_valid16), .out_ready(out_ready));

   typedef struct { logic [31:0] p; logic s; } exp_t;
   typedef struct { logic [31:0] v; logic s; int c; } hit_t;
   exp_t        q[$];
   hit_t        got[$];
   logic [31:0] ev[$];
   logic        es[$];
   int          eg[$];

   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
      longint x, y;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return 32'(x * y);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Hold the operand until the block accepts it on an edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input logic v);
      logic ok;
      A = a; B = b; in_signed = s; in_valid = v;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         ok = in_ready;
         tick();
         if (ok) return;
      end
      chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      A = 16'hDEAD; B = 16'hBEEF; in_signed = 1'b1;
      repeat (n) tick();
   endtask

   task automatic check_got(input string nm);
      chk({nm, "_count"}, got.size(), ev.size());
      for (int i = 0; i < ev.size() && i < got.size(); i++) begin
         chk({nm, "_val"}, got[i].v, ev[i]);
         chk({nm, "_sgn"}, got[i].s, es[i]);
         if (i > 0) chk({nm, "_gap"}, got[i].c - got[i-1].c, eg[i]);
      end
      got.delete(); ev.delete(); es.delete(); eg.delete();
   endtask

   // Scoreboard: handoffs are compared against the model in acceptance order; stalls must freeze out.
   logic [31:0] prev_out = '0;
   logic        prev_stall = 1'b0;
   exp_t        e;
   always @(negedge CLK) begin
      cyc++;
      if (RESETn) begin
         if (prev_stall) chk("stall_hold", out, prev_out);
         chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (out_valid && out_ready) begin
            got.push_back('{out, out_signed, cyc});
            if (q.size() == 0) chk("stale_result", out_valid, 0);
            else begin
               e = q.pop_front();
               chk("product", out, e.p);
               chk("out_signed", out_signed, e.s);
            end
         end
         if (in_valid && in_ready) q.push_back('{model(A, B, in_signed), in_signed});
         prev_stall = out_valid && !out_ready;
         prev_out   = out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int l1, l4, l16;
      logic [31:0] v1, v4, v16;
      logic any_stale;
      chk("model_unsigned", model(16'hFFFF, 16'hFFFF, 1'b0), 32'hFFFE0001);
      chk("model_signed", model(16'h7FFF, 16'h8000, 1'b1), 32'hC0008000);

      #1;
      chk("rst_out", out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_signed", out_signed, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      tick();

      // Unsigned max with standard latency
      send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("lat_wait", out_valid, 0);
         tick();
      end
      chk("lat_valid", out_valid, 1);
      chk("lat_out", out, 32'hFFFE0001);
      chk("lat_signed", out_signed, 0);
      idle(6);
      ev = '{32'hFFFE0001}; es = '{1'b0}; eg = '{0};
      check_got("unsigned");

      // Signed corners back-to-back
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      send(16'h8000, 16'h8000, 1'b1, 1'b1);
      send(16'h8000, 16'h0001, 1'b1, 1'b1);
      send(16'h7FFF, 16'h8000, 1'b1, 1'b1);
      idle(8);
      ev = '{32'h00000001, 32'h40000000, 32'hFFFF8000, 32'hC0008000};
      es = '{1'b1, 1'b1, 1'b1, 1'b1}; eg = '{0, 1, 1, 1};
      check_got("signed");

      // Mixed-mode alternating stream
      for (int i = 0; i < 8; i++) send(16'hFFFF, 16'hFFFF, 1'(i % 2), 1'b1);
      idle(8);
      for (int i = 0; i < 8; i++) begin
         ev.push_back(i % 2 ? 32'h00000001 : 32'hFFFE0001);
         es.push_back(1'(i % 2));
         eg.push_back(i == 0 ? 0 : 1);
      end
      check_got("mixed");

      // Backpressure: block the consumer for three edges once the first result shows up
      fork
         begin
            for (int i = 0; i < 6; i++) send(16'(4 * i + 3), 16'(4 * i + 5), 1'b0, 1'b1);
            in_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 40 && !out_valid; i++) tick();
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_valid_held", out_valid, 1);
            repeat (3) tick();
            out_ready = 1'b1;
         end
      join
      idle(10);
      ev = '{32'd15, 32'd63, 32'd143, 32'd255, 32'd399, 32'd575};
      es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; eg = '{0, 1, 1, 1, 1, 1};
      check_got("backpressure");

      // Bubbles in the input stream
      send(16'd2, 16'd3, 1'b0, 1'b1);
      send(16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
      send(16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
      send(16'd4, 16'd5, 1'b0, 1'b1);
      idle(8);
      ev = '{32'd6, 32'd20}; es = '{1'b0, 1'b0}; eg = '{0, 3};
      check_got("bubbles");

      // Reset mid-flight, asynchronous clear between edges
      send(16'd11, 16'd12, 1'b0, 1'b1);
      send(16'd13, 16'd14, 1'b1, 1'b1);
      send(16'd15, 16'd16, 1'b0, 1'b1);
      in_valid = 1'b0;
      #2;
      chk("mid_s1_valid_before", out_valid16, 1);
      RESETn = 1'b0;
      q.delete();
      #1;
      chk("arst_out", out, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_s1_out", out16, 0);
      chk("arst_s1_valid", out_valid16, 0);
      chk("arst_s16_valid", out_valid1, 0);
      #1;
      RESETn = 1'b1;
      any_stale = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         any_stale |= out_valid | out_valid1 | out_valid16;
      end
      chk("no_stale_after_reset", any_stale, 0);
      got.delete();

      // Latency scaling S=1, S=4, S=16
      send(16'h0010, 16'h0010, 1'b0, 1'b1);
      in_valid = 1'b0;
      l1 = -1; l4 = -1; l16 = -1; v1 = '0; v4 = '0; v16 = '0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid16 && l1 < 0) begin l1 = k; v1 = out16; end
         if (out_valid && l4 < 0) begin l4 = k; v4 = out; end
         if (out_valid1 && l16 < 0) begin l16 = k; v16 = out1; end
         tick();
      end
      chk("lat_s1", l1, 0);
      chk("lat_s4", l4, 3);
      chk("lat_s16", l16, 15);
      chk("val_s1", v1, 32'h00000100);
      chk("val_s4", v4, 32'h00000100);
      chk("val_s16", v16, 32'h00000100);
      ev = '{32'h00000100}; es = '{1'b0}; eg = '{0};
      check_got("after_reset");
      chk("scoreboard_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multiplier_pipe_stream.md
Name: multiplier_pipe_stream

Overview:
- Parametrised, fully pipelined array multiplier with valid/ready streaming handshake and a per-transaction signed/unsigned mode.
- Partial-product rows are split across S = bw/rows_per_stage register stages, giving one product per cycle at full throughput.
- Next-generation datapath multiplier for the arithmetic cluster. It is fed by operand producers and drains into accumulators that may apply backpressure.

Parameters:
- bw, 16, operand width in bits; product width is 2*bw.
- rows_per_stage, 4, partial-product rows summed per pipeline stage. It must divide bw exactly, otherwise elaboration fails. S = bw/rows_per_stage.

Ports:
- CLK  input  1  clock, rising edge.
- RESETn  input  1  asynchronous active-low reset.
- A  input  [bw:1]  multiplicand.
- B  input  [bw:1]  multiplier.
- in_signed  input  1  1 = treat A and B as two's complement; 0 = unsigned.
- in_valid  input  1  A, B and in_signed are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- out  output  [2*bw:1]  product.
- out_signed  output  1  in_signed value of the transaction now on out.
- out_valid  output  1  out and out_signed hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Clock and reset: one clock, CLK. RESETn is asynchronous and active-low.
- While RESETn=0:
  - out=0, out_signed=0, out_valid=0.
  - All internal stage valid bits are 0; stage data is 0.
  - in_ready=1.
- Acceptance:
  - A transfer happens on a rising edge where in_valid=1 and in_ready=1.
  - Output handoff happens on an edge where out_valid=1 and out_ready=1.
- Stall rule:
  - in_ready = !(out_valid && !out_ready). This is combinational, with no dependence on in_valid.
  - When in_ready=0, every stage register, including out, holds its value.
  - Stages advance together, with no bubble collapsing.
- Pipeline contents:
  - Each stage carries a valid bit, in_signed, the A and B operand copies still needed, and a 2*bw-bit running sum.
  - Stage k (k=1..S) adds partial-product rows (k-1)*rows_per_stage+1 .. k*rows_per_stage to the sum from stage k-1. Stage 0's sum is 0.
  - Stage S register drives out, out_signed and out_valid.
- Latency:
  - With no stall, operands accepted on edge n appear with out_valid=1 after edge n+S-1, i.e. S cycles counting the accept edge. Default S=4.
  - Throughput is 1 result per cycle.
- Bubbles: on an enabled edge with in_valid=0, a stage-1 entry with valid=0 is inserted. Invalid stages propagate as bubbles; out_valid follows the stage-S valid bit.
- Arithmetic:
  - Result is the exact 2*bw-bit product modulo 2^(2*bw); no overflow is possible.
  - Unsigned mode: row i = (B[i] ? A zero-extended : 0) << (i-1).
  - Signed mode: A is sign-extended to 2*bw bits; row i = (B[i] ? A_ext : 0) << (i-1) for i<bw. Row bw is subtracted (two's-complement negated) rather than added.
  - Adders ignore carry-out beyond bit 2*bw.
- Mode independence: mixed signed and unsigned transactions may be back-to-back in adjacent stages. Each transaction uses its own carried in_signed.
- Invalid operands: operands presented with in_valid=0 never affect any valid result.
- Simultaneous events: out_valid=1, out_ready=1 and in_valid=1 on the same edge means the result is handed off and a new operand is accepted on that edge.
- Reset mid-operation:
  - In-flight transactions are discarded and outputs clear immediately, asynchronously.
  - After RESETn rises, the first out_valid comes only from operands accepted after reset.
- No X propagation: out must hold 0 or a valid result, never X, after reset.

Test Plan:
- Unsigned, bw=16, rows_per_stage=4: A=0xFFFF, B=0xFFFF, in_signed=0 accepted on edge 1, out_ready=1 -> out=0xFFFE0001, out_valid=1 after edge 4, out_signed=0.
- Signed corner cases, back-to-back, out_ready=1:
  - (0xFFFF,0xFFFF) -> 0x00000001.
  - (0x8000,0x8000) -> 0x40000000.
  - (0x8000,0x0001) -> 0xFFFF8000.
  - (0x7FFF,0x8000) -> 0xC0008000.
  - Results appear on consecutive cycles, in order, with out_signed=1.
- Mixed-mode stream: alternate in_signed 0/1 with A=B=0xFFFF for 8 cycles -> out alternates 0xFFFE0001 / 0x00000001; out_signed alternates to match; no gaps.
- Backpressure:
  - Stream 6 products (3×5, 7×9, …); hold out_ready=0 for 3 cycles once out_valid=1.
  - in_ready must go 0 the same cycle, out must hold steady, and no result may be lost or duplicated.
  - After release, the remaining results arrive one per cycle.
- Bubbles: in_valid pattern 1,0,0,1 with (2,3),(x),(x),(4,5) -> out_valid pattern 1,0,0,1 carrying 6 then 20.
- Reset mid-flight:
  - Accept 3 operands, then pulse RESETn low between clock edges.
  - out=0 and out_valid=0 must hold immediately and asynchronously.
  - After release, no stale results appear; a new 0x0010×0x0010 → 0x00000100 arrives with the standard latency.
  - Repeat with rows_per_stage=1 (S=16) and rows_per_stage=16 (S=1) to confirm latency scaling.
